// File: rtl/parallel_mul_if.sv
// Operand/product bundle for parallel_mul: W-bit operands in, registered 2W-bit product out.
interface parallel_mul_if #(parameter int W = 1024);
  logic [W-1:0]   In1;
  logic [W-1:0]   In2;
  logic [2*W-1:0] Out;
  logic           out_valid;

  modport master (output In1, In2, input Out, out_valid);
  modport slave  (input In1, In2, output Out, out_valid);
endinterface

// File: rtl/parallel_mul.sv
// Unsigned WxW -> 2W multiplier: W partial products reduced by a clog2(W)-level binary adder tree.
// Build option PARALLEL_MUL_PIPE_EN registers the operands and every tree level (LAT = clog2(W)+1); default LAT = 1.

module parallel_mul_pp #(
  parameter int W   = 1024,
  parameter int IDX = 0
) (
  input  logic [W-1:0]   a,
  input  logic           b_bit,
  output logic [2*W-1:0] pp
);
  assign pp = b_bit ? ({{W{1'b0}}, a} << IDX) : '0;
endmodule

module parallel_mul #(
  parameter int W = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  parallel_mul_if.slave bus
);
`ifdef PARALLEL_MUL_PIPE_EN
  localparam int LAT = $clog2(W) + 1;
`else
  localparam int LAT = 1;
`endif
  localparam int STAGES = LAT - 1;

  logic [W-1:0]          op1, op2;
  logic [W-1:0][2*W-1:0] pp;
  logic [2*W-1:0]        root;
  logic [STAGES:0]       vld_pipe;

`ifdef PARALLEL_MUL_PIPE_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op1 <= '0;
      op2 <= '0;
    end else begin
      op1 <= bus.In1;
      op2 <= bus.In2;
    end
  end
`else
  assign op1 = bus.In1;
  assign op2 = bus.In2;
`endif

  for (genvar i = 0; i < W; i++) begin : g_lane
    parallel_mul_pp #(.W(W), .IDX(i)) u_pp (
      .a    (op1),
      .b_bit(op2[i]),
      .pp   (pp[i])
    );
  end

  // Heap-indexed tree: node n sums children 2n and 2n+1; indices >= W are the partial products.
  for (genvar n = 1; n < W; n++) begin : g_node
    logic [2*W-1:0] a, b, sum;
    if (2*n >= W) begin : g_leaf
      assign a = pp[2*n-W];
      assign b = pp[2*n+1-W];
    end else begin : g_inner
      assign a = g_node[2*n].sum;
      assign b = g_node[2*n+1].sum;
    end
`ifdef PARALLEL_MUL_PIPE_EN
    always_ff @(posedge clk) begin
      if (!resetn) sum <= '0;
      else         sum <= a + b;
    end
`else
    assign sum = a + b;
`endif
  end

  assign root = g_node[1].sum;

`ifdef PARALLEL_MUL_PIPE_EN
  assign bus.Out = root;
`else
  logic [2*W-1:0] out_q;
  always_ff @(posedge clk) begin
    if (!resetn) out_q <= '0;
    else         out_q <= root;
  end
  assign bus.Out = out_q;
`endif

  // A 1 enters every cycle outside reset, so out_valid rises exactly LAT edges after release.
  always_ff @(posedge clk) begin
    if (!resetn) vld_pipe <= '0;
    else         vld_pipe <= (vld_pipe << 1) | LAT'(1);
  end

  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_parallel_mul.sv
// Scoreboard bench for parallel_mul: driver queues expected products, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_parallel_mul;
  localparam int W = 1024;
`ifdef PARALLEL_MUL_PIPE_EN
  localparam int LAT = $clog2(W) + 1;
`else
  localparam int LAT = 1;
`endif

  typedef logic [W-1:0]   op_t;
  typedef logic [2*W-1:0] prod_t;
  typedef struct {
    prod_t p;
    int    due;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   strict = 1'b1;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parallel_mul_if #(.W(W)) bus ();
  parallel_mul #(.W(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  task automatic check(input string name, input prod_t got, input prod_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d: got hi=%h lo=%h, want hi=%h lo=%h", name, cyc,
               got[2*W-1 -: 64], got[63:0], want[2*W-1 -: 64], want[63:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard at its due cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        if (strict) begin
          total++; bad++;
          $display("FAIL unexpected_out cyc=%0d: got lo=%h, want no output", cyc, bus.Out[63:0]);
        end
      end else begin
        e = sb.pop_front();
        check(e.tag, bus.Out, e.p);
        check_int({e.tag, "_lat"}, cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL %s_missing cyc=%0d: got out_valid=0, want valid product due at %0d", e.tag, cyc, e.due);
    end
  end

  task automatic step(input op_t a, input op_t b, input logic rn, input prod_t want, input string tag);
    @(negedge clk); #1;
    if (!resetn) begin
      check("rst_out", bus.Out, '0);
      check_int("rst_vld", int'(bus.out_valid), 0);
    end
    if (!rn)
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    bus.In1 = a;
    bus.In2 = b;
    resetn  = rn;
    if (rn) sb.push_back('{p: want, due: cyc + LAT, tag: tag});
  endtask

  function automatic op_t rnd_op();
    op_t r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0: r = op_t'(r[31:0]);
      1: begin r = '0; r[$urandom_range(0, W-1)] = 1'b1; end
      2: r = '1;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    op_t   ones, x, p1023, p512, p511;
    prod_t e_ones, e1023;
    op_t   a, b;
    int    ms_a [5] = '{2, 3, 4, 5, 6};
    int    ms_b [5] = '{3, 4, 5, 6, 7};
    int    ms_p [5] = '{6, 12, 20, 30, 42};

    ones  = '1;
    x     = '0; x[W-1 -: 64] = 64'hDEAD_BEEF_0123_4567; x[63:0] = 64'h89AB_CDEF_FEDC_BA98;
    p1023 = '0; p1023[W-1] = 1'b1;
    p512  = '0; p512[W/2] = 1'b1;
    p511  = '0; p511[W/2-1] = 1'b1;
    e_ones = '0; e_ones[0] = 1'b1; e_ones[2*W-1:W+1] = '1;
    e1023  = '0; e1023[W-1] = 1'b1;

    bus.In1 = op_t'(5);
    bus.In2 = op_t'(5);

    // Reset held with operands 5*5, then released
    for (int i = 0; i < 3; i++) step(op_t'(5), op_t'(5), 1'b0, '0, "rst");
    step(op_t'(5), op_t'(5), 1'b1, prod_t'(25), "rst_release");

    step(op_t'(32'hFFFF_FFFF), op_t'(32'hFFFF_FFFF), 1'b1, prod_t'(64'hFFFF_FFFE_0000_0001), "small_ones");
    step(ones, ones, 1'b1, e_ones, "full_ones");
    step('0, ones, 1'b1, '0, "zero_a");
    step(ones, '0, 1'b1, '0, "zero_b");
    step(x, op_t'(1), 1'b1, {{W{1'b0}}, x}, "in2_one");

    // Back-to-back stream
    step(op_t'(3), op_t'(7), 1'b1, prod_t'(21), "stream0");
    step('0, ones, 1'b1, '0, "stream1");
    step(op_t'(1), p1023, 1'b1, e1023, "stream2");
    step(p512, p511, 1'b1, e1023, "stream3");

    // Mid-stream reset with five products in flight
    for (int i = 0; i < 5; i++)
      step(op_t'(ms_a[i]), op_t'(ms_b[i]), 1'b1, prod_t'(ms_p[i]), "inflight");
    step(op_t'(9), op_t'(9), 1'b0, '0, "midrst");
    step(op_t'(4), op_t'(4), 1'b1, prod_t'(16), "post_rst0");
    step(op_t'(11), op_t'(13), 1'b1, prod_t'(143), "post_rst1");
    step(ones, op_t'(2), 1'b1, {{(W-1){1'b0}}, ones, 1'b0}, "post_rst2");

    for (int i = 0; i < 1000; i++) begin
      a = rnd_op();
      b = rnd_op();
      step(a, b, 1'b1, prod_t'(a) * prod_t'(b), "rand");
    end

    // Drain: later outputs of the held operands are no longer scored
    strict = 1'b0;
    for (int i = 0; i < LAT + 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check_int("drain_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
